// File: rtl/cache_axi_pkg.sv
// Shared types and helpers for the cache-to-AXI bridge.
// Arbitration mode is selected by CACHE_AXI_RR_ARB_EN (see cache_axi_arb).
package cache_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Owner encoding doubles as the bit index into the arbiter grant vector.
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;
    localparam int   GNT_INST   = 0;
    localparam int   GNT_DATA   = 1;

    // Byte-lane strobe for a single beat on a 32-bit bus.
    function automatic logic [3:0] size_to_strb(input logic [1:0] size,
                                                input logic [1:0] offset);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << offset;
            2'd1:    strb = 4'b0011 << offset;
            default: strb = 4'hF;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/cache_axi_arb.sv
// Two-way request arbiter for the cache miss ports.
// CACHE_AXI_RR_ARB_EN defined: round-robin (reset favours the data side).
// Undefined: fixed priority, data side wins a simultaneous request.
// Grant is one-hot (bit GNT_INST / GNT_DATA) and only issued while idle.
module cache_axi_arb
    import cache_axi_pkg::*;
(
`ifdef CACHE_AXI_RR_ARB_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic       idle,
    input  logic       inst_req,
    input  logic       data_req,
    output logic [1:0] grant
);

    logic prio_data;

`ifdef CACHE_AXI_RR_ARB_EN
    logic prio_data_q;

    // Hand priority to the side that was not just granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_data_q <= 1'b1;
        end else if (grant[GNT_INST]) begin
            prio_data_q <= 1'b1;
        end else if (grant[GNT_DATA]) begin
            prio_data_q <= 1'b0;
        end
    end

    assign prio_data = prio_data_q;
`else
    assign prio_data = 1'b1;
`endif

    // One-hot grant; a lone requester always wins, a tie goes to prio_data.
    always_comb begin
        grant           = 2'b00;
        grant[GNT_DATA] = idle & data_req & (~inst_req | prio_data);
        grant[GNT_INST] = idle & inst_req & (~data_req | ~prio_data);
    end

endmodule

// File: rtl/cache_axi_bridge.sv
// Single-outstanding bridge from the instruction/data cache miss ports
// (req/addr_ok/data_ok) to one AXI4 master port. Each request becomes a
// single-beat AXI read or write. Arbitration mode: CACHE_AXI_RR_ARB_EN.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for a request; addr_ok issued here only
// ST_RD_ADDR | arvalid held until arready
// ST_RD_DATA | rready held until rvalid; data_ok on that cycle
// ST_WR      | AW and W presented, each drops after its handshake
// ST_WR_RESP | bready held until bvalid; data_data_ok on that cycle
module cache_axi_bridge
    import cache_axi_pkg::*;
#(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_t      state_q;
    logic        owner_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        idle;
    logic [1:0]  grant;
    logic        rd_done;
    logic        wr_done;
    logic        aw_done;
    logic        w_done;
    logic [3:0]  axi_id;

    // Responses complete the transaction whatever their status or ID.
    logic        unused_axi_resp;
    assign unused_axi_resp = ^{rid, rresp, rlast, bid, bresp};

    assign idle = (state_q == ST_IDLE);

    cache_axi_arb u_arb (
`ifdef CACHE_AXI_RR_ARB_EN
        .clk      (clk),
        .rst      (rst),
`endif
        .idle     (idle),
        .inst_req (inst_req),
        .data_req (data_req),
        .grant    (grant)
    );

    // A channel counts as done once its handshake has happened or is happening now.
    assign aw_done = ~awvalid | awready;
    assign w_done  = ~wvalid | wready;

    // Main sequencer with registered AXI valid/ready and latched request fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_DATA;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant[GNT_DATA]) begin
                        owner_q <= OWNER_DATA;
                        wr_q    <= data_wr;
                        size_q  <= data_size;
                        addr_q  <= data_addr;
                        wdata_q <= data_wdata;
                        if (data_wr) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state_q <= ST_WR;
                        end else begin
                            arvalid <= 1'b1;
                            state_q <= ST_RD_ADDR;
                        end
                    end else if (grant[GNT_INST]) begin
                        owner_q <= OWNER_INST;
                        wr_q    <= 1'b0;
                        size_q  <= inst_size;
                        addr_q  <= inst_addr;
                        wdata_q <= 32'd0;
                        arvalid <= 1'b1;
                        state_q <= ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_q <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        rready  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready  <= 1'b1;
                        state_q <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    arvalid <= 1'b0;
                    rready  <= 1'b0;
                    awvalid <= 1'b0;
                    wvalid  <= 1'b0;
                    bready  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign inst_addr_ok = grant[GNT_INST];
    assign data_addr_ok = grant[GNT_DATA];

    assign rd_done = (state_q == ST_RD_DATA) & rvalid;
    assign wr_done = (state_q == ST_WR_RESP) & bvalid & wr_q;

    assign inst_data_ok = rd_done & (owner_q == OWNER_INST);
    assign data_data_ok = (rd_done & (owner_q == OWNER_DATA)) | wr_done;

    // Read data only shows on the owner's port during its data_ok cycle.
    assign inst_rdata = inst_data_ok ? rdata : 32'd0;
    assign data_rdata = (rd_done & (owner_q == OWNER_DATA)) ? rdata : 32'd0;

    assign axi_id  = (owner_q == OWNER_DATA) ? ID_DATA : ID_INST;

    assign arid    = axi_id;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = AXI_BURST_INCR;

    assign awid    = axi_id;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = AXI_BURST_INCR;

    assign wdata   = wdata_q;
    assign wstrb   = size_to_strb(size_q, addr_q[1:0]);
    assign wlast   = 1'b1;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: directed cases plus randomized
// request/slave timing, checked against a transaction-level model.
module tb_cache_axi_bridge;

    typedef struct {
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          d1;
        int          d2;
        int          d3;
        logic [1:0]  resp;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int   checks = 0;
    int   failures = 0;
    txn_t inst_t, data_t;
    bit   inst_pend = 0, data_pend = 0;
    bit   prio_data = 1;

    cache_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Strobe from the access width in bytes; word accesses are always full lanes.
    function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [1:0] off);
        int bytes;
        int mask;
        if (size == 2'd2) return 4'hF;
        bytes = 1 << size;
        mask  = (1 << bytes) - 1;
        return 4'((mask << off) & 15);
    endfunction

    function automatic txn_t mk(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int d1, input int d2, input int d3, input logic [1:0] resp);
        txn_t t;
        t.wr = wr; t.size = size; t.addr = addr; t.wdata = wd; t.rdata = rd;
        t.d1 = d1; t.d2 = d2; t.d3 = d3; t.resp = resp;
        return t;
    endfunction

    function automatic txn_t rnd(input bit allow_wr);
        return mk(allow_wr ? 1'($urandom_range(0, 1)) : 1'b0, 2'($urandom_range(0, 2)),
                  $urandom, $urandom, $urandom, $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)));
    endfunction

    // Drive pending requests, check the grant, then play the slave for the winner.
    task automatic serve();
        bit   win_data;
        txn_t t;
        int   c;
        bit   aw_hs, w_hs;
        int   aw_n, w_n;
        logic [3:0] exp_id;
        @(negedge clk);
        inst_req  = inst_pend; inst_addr = inst_t.addr; inst_size = inst_t.size;
        data_req  = data_pend; data_wr = data_t.wr; data_size = data_t.size;
        data_addr = data_t.addr; data_wdata = data_t.wdata;
        win_data  = (inst_pend && data_pend) ? prio_data : data_pend;
        #1;
        chk("inst_addr_ok", inst_addr_ok, !win_data);
        chk("data_addr_ok", data_addr_ok, win_data);
`ifdef CACHE_AXI_RR_ARB_EN
        prio_data = !win_data;
`endif
        t      = win_data ? data_t : inst_t;
        exp_id = win_data ? 4'd1 : 4'd0;
        @(posedge clk); #1;
        if (win_data) begin data_pend = 0; data_req = 0; end
        else          begin inst_pend = 0; inst_req = 0; end
        if (!t.wr) begin
            for (int i = 0; i <= t.d1; i++) begin
                @(negedge clk); arready = (i == t.d1); #1;
                chk("arvalid", arvalid, 1);
                chk("addr_ok_busy", {inst_addr_ok, data_addr_ok}, 0);
                if (i == t.d1) begin
                    chk("araddr", araddr, t.addr);
                    chk("arid", arid, exp_id);
                    chk("arsize", arsize, {1'b0, t.size});
                    chk("arlen", arlen, 0);
                    chk("arburst", arburst, 2'b01);
                end
                @(posedge clk); #1; arready = 0;
            end
            for (int i = 0; i <= t.d2; i++) begin
                @(negedge clk);
                rvalid = (i == t.d2); rdata = t.rdata; rresp = t.resp;
                rid = 4'($urandom); rlast = 1'b1; #1;
                chk("rready", rready, 1);
                chk("arvalid_low", arvalid, 0);
                chk("addr_ok_busy", {inst_addr_ok, data_addr_ok}, 0);
                chk("rd_data_ok", {inst_data_ok, data_data_ok},
                    (i == t.d2) ? (win_data ? 2'b01 : 2'b10) : 2'b00);
                if (i == t.d2)
                    chk("rd_rdata", win_data ? data_rdata : inst_rdata, t.rdata);
                @(posedge clk); #1; rvalid = 0;
            end
            chk("rready_done", rready, 0);
        end else begin
            aw_hs = 0; w_hs = 0; c = 0; aw_n = 0; w_n = 0;
            while (!(aw_hs && w_hs) && c < 16) begin
                @(negedge clk);
                awready = !aw_hs && (c >= t.d1);
                wready  = !w_hs && (c >= t.d2); #1;
                chk("awvalid", awvalid, !aw_hs);
                chk("wvalid", wvalid, !w_hs);
                chk("bready_early", bready, 0);
                chk("wr_data_ok_early", {inst_data_ok, data_data_ok}, 0);
                if (awvalid && awready) begin
                    aw_n++;
                    chk("awaddr", awaddr, t.addr);
                    chk("awid", awid, 4'd1);
                    chk("awsize", awsize, {1'b0, t.size});
                    chk("awlen", awlen, 0);
                    chk("awburst", awburst, 2'b01);
                end
                if (wvalid && wready) begin
                    w_n++;
                    chk("wdata", wdata, t.wdata);
                    chk("wstrb", wstrb, exp_strb(t.size, t.addr[1:0]));
                    chk("wlast", wlast, 1);
                end
                @(posedge clk); #1;
                if (awready) aw_hs = 1;
                if (wready)  w_hs = 1;
                awready = 0; wready = 0; c++;
            end
            chk("aw_handshakes", aw_n, 1);
            chk("w_handshakes", w_n, 1);
            for (int i = 0; i <= t.d3; i++) begin
                @(negedge clk);
                bvalid = (i == t.d3); bresp = t.resp; bid = 4'($urandom); #1;
                chk("bready", bready, 1);
                chk("aw_w_low", {awvalid, wvalid}, 0);
                chk("wr_data_ok", {inst_data_ok, data_data_ok}, (i == t.d3) ? 2'b01 : 2'b00);
                @(posedge clk); #1; bvalid = 0;
            end
            chk("bready_done", bready, 0);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((inst_pend || data_pend) && guard < 4) begin
            serve();
            guard++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        rst = 1'b1;
        inst_req = 0; inst_size = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        inst_t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        data_t = inst_t;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
        chk("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_wdata", wdata, 0);
        rst = 1'b0;

        // Data read, 3-cycle slave latency.
        data_t = mk(0, 2, 32'h1000_0004, 0, 32'hDEAD_BEEF, 0, 3, 0, 0);
        data_pend = 1; drain();
        // Byte write, wready two cycles after awready.
        data_t = mk(1, 0, 32'h2000_0003, 32'hAB00_0000, 0, 0, 2, 1, 0);
        data_pend = 1; drain();
        // Simultaneous requests held across two transactions.
        inst_t = mk(0, 2, 32'h0040_0010, 0, 32'h1234_5678, 0, 0, 0, 0);
        data_t = mk(0, 1, 32'h1000_0102, 0, 32'h8765_4321, 1, 0, 0, 0);
        inst_pend = 1; data_pend = 1; drain();
        // awready and wready together, then W before AW.
        data_t = mk(1, 1, 32'h3000_0002, 32'h5A5A_0000, 0, 1, 1, 0, 0);
        data_pend = 1; drain();
        data_t = mk(1, 2, 32'h3000_0008, 32'hCAFE_F00D, 0, 2, 0, 0, 0);
        data_pend = 1; drain();
        // Error response still completes.
        data_t = mk(0, 2, 32'h4000_0000, 0, 32'h0BAD_0BAD, 0, 1, 0, 2'b10);
        data_pend = 1; drain();

        // Reset while in RD_DATA, with rvalid arriving at the same moment.
        @(negedge clk);
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h5000_0010; #1;
        chk("rstmid_addr_ok", data_addr_ok, 1);
        @(posedge clk); #1; data_req = 0;
        @(negedge clk); arready = 1; #1;
        chk("rstmid_arvalid", arvalid, 1);
        @(posedge clk); #1; arready = 0;
        @(negedge clk); #1;
        chk("rstmid_rready", rready, 1);
        rvalid = 1; rdata = 32'h7777_7777; rst = 1; #1;
        chk("rstmid_clear", {rready, arvalid, data_data_ok, inst_data_ok}, 0);
        prio_data = 1;
        @(posedge clk); #1; rvalid = 0;
        @(negedge clk); rst = 0;
        data_t = mk(0, 2, 32'h5000_0010, 0, 32'h600D_600D, 0, 0, 0, 0);
        data_pend = 1; drain();

        // Randomized traffic, sometimes with both sides requesting together.
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 2);
            if (sel != 1) begin inst_t = rnd(0); inst_pend = 1; end
            if (sel != 0) begin data_t = rnd(1); data_pend = 1; end
            drain();
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_axi_bridge.md
# cache_axi_bridge

Single-outstanding bridge between the two SRAM-like cache miss ports (instruction cache, data cache) and one AXI4 master port. Sits directly downstream of the data cache and instruction cache: it arbitrates their `req/addr_ok/data_ok` transactions and turns each one into a single-beat AXI read (AR/R) or write (AW/W/B). It returns per-requester `addr_ok`/`data_ok` handshakes and read data.

## Interface
- `ID_INST`, default 4'd0: AXI ID used for instruction-side reads.
- `ID_DATA`, default 4'd1: AXI ID used for data-side transactions.
- `clk  in  1`: clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `inst_req, inst_size[1:0], inst_addr[31:0]  in`: instruction-side read request (always read).
- `inst_addr_ok, inst_data_ok  out  1`: instruction-side handshakes.
- `inst_rdata  out  32`: instruction-side read data.
- `data_req, data_wr  in  1`; `data_size  in  2`; `data_addr, data_wdata  in  32`: data-side request.
- `data_addr_ok, data_data_ok  out  1`: data-side handshakes.
- `data_rdata  out  32`: data-side read data.
- `arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arvalid  out`; `arready  in`: AXI read-address channel.
- `rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid  in`; `rready  out`: AXI read-data channel.
- `awid, awaddr, awlen, awsize, awburst, awvalid  out`; `awready  in`: AXI write-address channel. Widths are the same as the AR channel.
- `wdata[31:0], wstrb[3:0], wlast, wvalid  out`; `wready  in`: AXI write-data channel.
- `bid[3:0], bresp[1:0], bvalid  in`; `bready  out`: AXI write-response channel.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - RD_ADDR: `arvalid=1`.
  - RD_DATA: `rready=1`.
  - WR: AW and W are presented.
  - WR_RESP: `bready=1`.
- In IDLE, if either `req` is high, the arbiter grants one requester. The granted side's `addr_ok=1` combinationally in that same cycle. Owner, wr, size, addr and wdata are latched at the edge.
  - Next state is RD_ADDR if the request is a read, WR if it is a write.
- RD_ADDR → RD_DATA on `arvalid & arready`.
- RD_DATA → IDLE on `rvalid` (`rready` is held high). In that cycle the owner's `data_ok=1` and its `rdata = rdata` (combinational pass-through).
- WR: `awvalid` and `wvalid` each drop independently after their own handshake. Go to WR_RESP once both handshakes are done, in either order or in the same cycle.
- WR_RESP → IDLE on `bvalid`. The data side gets `data_data_ok=1` in that cycle.
- Fixed AXI fields: `arlen=awlen=0`, `arburst=awburst=2'b01`, `wlast=1`, `a*size={1'b0,size}`.
  - ID is `ID_INST` or `ID_DATA` according to the owner.
- `wstrb`:
  - size 0: `4'b0001<<addr[1:0]`
  - size 1: `4'b0011<<addr[1:0]`
  - size 2: `4'hF`
- `wdata` is passed unmodified; the data cache has already placed bytes in their lanes.
- `rresp`, `bresp`, `rid` and `bid` are ignored: the transaction completes with `data_ok` regardless. Only one transaction is ever outstanding.
- No `addr_ok` is asserted outside IDLE. An ungranted requester holds `req` and is served later.

## Timing
- Reset values: every AXI `valid`/`ready` output, `inst_addr_ok`, `inst_data_ok`, `data_addr_ok`, `data_data_ok` = 0. Latched address and wdata = 0. State = IDLE. Arbiter pointer favours data.
- Read with zero-wait slave: `req`/`addr_ok` in cycle N; `arvalid` in N+1 (`arready` in N+1); `rvalid`/`data_ok` in N+2.
- Write with zero-wait slave: `addr_ok` in N; AW+W in N+1; `bvalid`/`data_ok` in N+2.
- Back-to-back: after `data_ok` in cycle M, the earliest next `addr_ok` is in M+1 (IDLE re-entered at the edge).
- Reset asserted mid-transaction: all outputs clear asynchronously and the FSM returns to IDLE. The AXI slave is reset by the same `rst`; no response is awaited.
- Outputs that depend on latched registers are stable for the whole transaction. Only `addr_ok`, `data_ok` and `rdata` are combinational.

## Configuration
- `CACHE_AXI_RR_ARB_EN` defined: round-robin arbitration. On a simultaneous request, the side not granted last time wins; the pointer updates on each grant.
- Not defined: fixed priority, data side always wins a simultaneous request.

## Structure
- Package `cache_axi_pkg` holds:
  - the state enum
  - `AXI_BURST_INCR`
  - `OWNER_INST`/`OWNER_DATA` constants
  - a `size_to_strb(size, offset)` function
- One sub-module, `cache_axi_arb`: the two-way request arbiter (fixed or round-robin per macro). Outputs a one-hot grant, gated by IDLE.

## Test plan
- Data read, size 2, addr `0x1000_0004`; slave returns `0xDEADBEEF` after 3 cycles → `araddr=0x1000_0004`, `arid=1`, `arsize=2`; `data_data_ok` pulses once with `data_rdata=0xDEADBEEF`.
- Data write, size 0, addr `0x2000_0003`, wdata `0xAB000000` → `wstrb=4'b1000`, `awsize=0`, `wlast=1`. The bench delays `wready` 2 cycles after `awready`. `data_data_ok` only on `bvalid`.
- `inst_req` and `data_req` high in the same cycle, held for 2 transactions → without the macro: data then inst. With the macro and last grant = data: inst then data.
- `awready` and `wready` arrive in the same cycle, and in the other test in reversed order → exactly one AW and one W handshake each; WR_RESP entered once.
- `rst` pulsed while in RD_DATA → `rready`, `arvalid`, `data_ok` go to 0 immediately; a new read after release completes normally.
- Slave returns `rresp=2'b10` → `data_ok` still pulses; FSM returns to IDLE.
